act_lut_loader: RTL and testbench

- Writable activation-function table: the write-side counterpart of the fixed LUT that feeds the activation interpolator.
- Accepts a stream of signed fixed-point sample points over a valid/ready handshake and stores them in a (2**ADDR_W)+1 entry register table.
- Serves the interpolator's read interface: address -> base, next_data.
- Lets a layer's activation (sigmoid, tanh, ReLU approximations) be reprogrammed at run time instead of being fixed at generation.

---
 rtl/act_lut_pkg.sv | 21 ++
 rtl/act_lut_regfile.sv | 38 +++
 rtl/act_lut_loader.sv | 126 ++++++++++++
 tb/tb_act_lut_loader.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/act_lut_pkg.sv
// Shared constants and types for the writable activation table.
//   WIDTH  : entry width, signed Q4.4
//   ADDR_W : lookup address width
//   DEPTH  : number of table entries (2**ADDR_W + 1)
//   CNT_W  : width of an entry index / entry count (reaches DEPTH)
package act_lut_pkg;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = (2 ** ADDR_W) + 1;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic signed [WIDTH-1:0] entry_t;

endpackage

// File: rtl/act_lut_regfile.sv
// Register table for the activation LUT: one write port, two combinational
// read ports, all entries cleared on reset.
//   clk, rst        : clock, synchronous active-high reset
//   we/waddr/wdata  : write port
//   raddr0/rdata0   : read port 0
//   raddr1/rdata1   : read port 1
module act_lut_regfile
  import act_lut_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [CNT_W-1:0] waddr,
  input  entry_t           wdata,
  input  logic [CNT_W-1:0] raddr0,
  input  logic [CNT_W-1:0] raddr1,
  output entry_t           rdata0,
  output entry_t           rdata1
);

  entry_t mem [DEPTH];

  // Table storage; out-of-range writes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[CNT_W'(i)] <= '0;
      end
    end else if (we && (waddr < CNT_W'(DEPTH))) begin
      mem[waddr] <= wdata;
    end
  end

  // Read indices never exceed DEPTH-1 (top-level address is ADDR_W bits).
  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/act_lut_loader.sv
// Run-time loadable activation table. Samples stream in over valid/ready in
// index order; once all DEPTH entries are written the table is published to
// the interpolator's combinational read port.
//   clk, rst      : clock, synchronous active-high reset
//   load_start    : pulse, begins/restarts a load
//   sample_valid  : sample_data valid
//   sample_data   : entry value (signed Q4.4)
//   sample_ready  : block is accepting samples (state LOAD)
//   table_valid   : full table loaded
//   load_error    : sticky, sample offered outside LOAD
//   entry_count   : entries written in the current load
//   address       : lookup index
//   base          : entry[address]        (0 while table_valid is low)
//   next_data     : entry[address + 1]    (0 while table_valid is low)
module act_lut_loader
  import act_lut_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              sample_valid,
  input  logic [WIDTH-1:0]  sample_data,
  output logic              sample_ready,
  output logic              table_valid,
  output logic              load_error,
  output logic [CNT_W-1:0]  entry_count,
  input  logic [ADDR_W-1:0] address,
  output logic [WIDTH-1:0]  base,
  output logic [WIDTH-1:0]  next_data
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;

  logic             we;
  logic [CNT_W-1:0] waddr;
  logic             accept;
  logic [CNT_W-1:0] raddr0, raddr1;
  entry_t           rdata0, rdata1;

  // State, counter and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign accept = sample_valid && (state_q == LOAD);

  // Next-state, counter and write-port control.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    valid_d = valid_q;
    error_d = error_q;
    we      = 1'b0;
    waddr   = count_q;

    if (load_start) begin
      // Restart takes priority; a coincident accepted sample becomes entry 0.
      state_d = LOAD;
      count_d = '0;
      valid_d = 1'b0;
      error_d = 1'b0;
      if (accept) begin
        we      = 1'b1;
        waddr   = '0;
        count_d = CNT_W'(1);
      end
    end else begin
      unique case (state_q)
        LOAD: begin
          if (accept) begin
            we      = 1'b1;
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_W'(DEPTH - 1)) begin
              state_d = DONE;
              valid_d = 1'b1;
            end
          end
        end
        IDLE, DONE: begin
          if (sample_valid) begin
            error_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign raddr0 = CNT_W'(address);
  assign raddr1 = CNT_W'(address) + CNT_W'(1);

  act_lut_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (entry_t'(sample_data)),
    .raddr0 (raddr0),
    .raddr1 (raddr1),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  assign sample_ready = (state_q == LOAD);
  assign table_valid  = valid_q;
  assign load_error   = error_q;
  assign entry_count  = count_q;

  // Hide the table until it is complete.
  assign base      = valid_q ? WIDTH'(rdata0) : '0;
  assign next_data = valid_q ? WIDTH'(rdata1) : '0;

endmodule

// File: tb/tb_act_lut_loader.sv
// Directed self-checking bench for act_lut_loader.
module tb_act_lut_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start;
  logic       sample_valid;
  logic [7:0] sample_data;
  logic       sample_ready;
  logic       table_valid;
  logic       load_error;
  logic [4:0] entry_count;
  logic [3:0] address;
  logic [7:0] base;
  logic [7:0] next_data;

  int tests = 0;
  int fails = 0;

  act_lut_loader dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .table_valid  (table_valid),
    .load_error   (load_error),
    .entry_count  (entry_count),
    .address      (address),
    .base         (base),
    .next_data    (next_data)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference sample pattern 8*i-64.
  function automatic logic [7:0] ramp(input int i);
    return 8'(8 * i - 64);
  endfunction

  task automatic pulse_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Send ramp(first..last); with gap, sample_valid drops every other cycle
  // and the table must stay hidden until the final accept.
  task automatic send_ramp(input int first, input int last, input bit gap);
    for (int i = first; i <= last; i++) begin
      sample_valid = 1'b1;
      sample_data  = ramp(i);
      tick();
      sample_valid = 1'b0;
      if (gap && i < last) begin
        check("gap_table_valid", 32'(table_valid), 32'd0);
        check("gap_base",        32'(base),        32'd0);
        tick();
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    load_start   = 1'b0;
    sample_valid = 1'b0;
    sample_data  = 8'h00;
    address      = 4'd5;

    // Reset then idle
    tick();
    tick();
    check("rst_table_valid",  32'(table_valid),  32'd0);
    check("rst_sample_ready", 32'(sample_ready), 32'd0);
    check("rst_entry_count",  32'(entry_count),  32'd0);
    check("rst_base",         32'(base),         32'd0);
    check("rst_next_data",    32'(next_data),    32'd0);
    check("rst_load_error",   32'(load_error),   32'd0);
    rst = 1'b0;
    tick();

    // Full back-to-back load
    pulse_load();
    check("load_ready",       32'(sample_ready), 32'd1);
    check("load_count0",      32'(entry_count),  32'd0);
    send_ramp(0, 15, 1'b0);
    check("pre17_table_valid", 32'(table_valid), 32'd0);
    check("pre17_count",       32'(entry_count), 32'd16);
    send_ramp(16, 16, 1'b0);
    check("full_table_valid", 32'(table_valid),  32'd1);
    check("full_count",       32'(entry_count),  32'd17);
    check("full_ready",       32'(sample_ready), 32'd0);
    address = 4'd3;
    #1;
    check("full_base_a3",     32'(base),      32'h0D8);
    check("full_next_a3",     32'(next_data), 32'h0E0);
    address = 4'd15;
    #1;
    check("full_base_a15",    32'(base),      32'h038);
    check("full_next_a15",    32'(next_data), 32'h040);

    // Gapped load from a cleared table
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulse_load();
    send_ramp(0, 16, 1'b1);
    check("gap_done_valid",   32'(table_valid), 32'd1);
    check("gap_done_count",   32'(entry_count), 32'd17);
    address = 4'd0;
    #1;
    check("gap_base_a0",      32'(base),      32'h0C0);
    check("gap_next_a0",      32'(next_data), 32'h0C8);
    address = 4'd15;
    #1;
    check("gap_base_a15",     32'(base),      32'h038);
    check("gap_next_a15",     32'(next_data), 32'h040);

    // Restart colliding with an accepted sample
    pulse_load();
    send_ramp(0, 4, 1'b0);
    check("coll_count5",      32'(entry_count), 32'd5);
    load_start   = 1'b1;
    sample_valid = 1'b1;
    sample_data  = 8'h11;
    tick();
    load_start   = 1'b0;
    sample_valid = 1'b0;
    check("coll_count1",      32'(entry_count), 32'd1);
    check("coll_table_valid", 32'(table_valid), 32'd0);
    send_ramp(1, 16, 1'b0);
    check("coll_done_valid",  32'(table_valid), 32'd1);
    address = 4'd0;
    #1;
    check("coll_base_a0",     32'(base),      32'h011);
    check("coll_next_a0",     32'(next_data), 32'h0C8);

    // Sample offered in DONE
    sample_valid = 1'b1;
    sample_data  = 8'h7F;
    tick();
    sample_valid = 1'b0;
    check("err_set",          32'(load_error),  32'd1);
    check("err_base_a0",      32'(base),        32'h011);
    check("err_count",        32'(entry_count), 32'd17);
    tick();
    check("err_sticky",       32'(load_error),  32'd1);
    pulse_load();
    check("err_cleared",      32'(load_error),  32'd0);
    check("err_restart_tv",   32'(table_valid), 32'd0);

    // Reset in the middle of a load
    for (int i = 0; i < 9; i++) begin
      sample_valid = 1'b1;
      sample_data  = 8'h55;
      tick();
    end
    sample_valid = 1'b0;
    check("mid_count9",       32'(entry_count), 32'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_count",    32'(entry_count),  32'd0);
    check("mid_rst_ready",    32'(sample_ready), 32'd0);
    check("mid_rst_valid",    32'(table_valid),  32'd0);
    pulse_load();
    send_ramp(0, 16, 1'b0);
    address = 4'd0;
    #1;
    check("new_base_a0",      32'(base),      32'h0C0);
    check("new_next_a0",      32'(next_data), 32'h0C8);
    address = 4'd8;
    #1;
    check("new_base_a8",      32'(base),      32'h000);
    check("new_next_a8",      32'(next_data), 32'h008);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
